// File: rtl/jtag_scan_checker.sv
// Boundary-scan TDO response checker: records TDI stimulus and TDO response per DR scan
// and compares a response field against the stimulus of the scan LATENCY scans earlier.
module jtag_scan_checker #(
    parameter int BSC_SIZE   = 14,
    parameter int TEST_WIDTH = 5,
    parameter int OUT_LSB    = 9,
    parameter int LATENCY    = 1,
    parameter int CNT_W      = 16
) (
    input  logic                  TCK,
    input  logic                  TRST_n,
    input  logic                  tdi,
    input  logic                  tdo,
    input  logic                  shift_en,
    input  logic                  strobe,
    input  logic                  clear,
    input  logic [TEST_WIDTH-1:0] mask,
    output logic                  cmp_valid,
    output logic [TEST_WIDTH-1:0] mismatch_bits,
    output logic                  error,
    output logic                  length_err,
    output logic [CNT_W-1:0]      err_count,
    output logic [CNT_W-1:0]      scan_count,
    output logic [CNT_W-1:0]      first_fail_idx,
    output logic [TEST_WIDTH-1:0] first_fail_bits
);

    localparam int              BCW     = $clog2(BSC_SIZE + 2);
    localparam logic [BCW-1:0]  BC_FULL = BCW'(BSC_SIZE);
    localparam logic [BCW-1:0]  BC_SAT  = BCW'(BSC_SIZE + 1);
    localparam logic [2:0]      LAT     = 3'(LATENCY);

    logic [BSC_SIZE-1:0]   stim_sr_q, stim_sr_d;
    logic [BSC_SIZE-1:0]   resp_sr_q, resp_sr_d;
    logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
    logic                  shift_en_dly_q, shift_en_dly_d;
    logic [TEST_WIDTH-1:0] hist_q [LATENCY];
    logic [TEST_WIDTH-1:0] hist_d [LATENCY];
    logic [2:0]            hist_fill_q, hist_fill_d;
    logic                  cmp_valid_q, cmp_valid_d;
    logic [TEST_WIDTH-1:0] mismatch_bits_q, mismatch_bits_d;
    logic                  error_q, error_d;
    logic                  length_err_q, length_err_d;
    logic [CNT_W-1:0]      err_count_q, err_count_d;
    logic [CNT_W-1:0]      scan_count_q, scan_count_d;
    logic [CNT_W-1:0]      first_fail_idx_q, first_fail_idx_d;
    logic [TEST_WIDTH-1:0] first_fail_bits_q, first_fail_bits_d;

    logic                  eos;
    logic [TEST_WIDTH-1:0] mismatch;
    logic                  unused_bits;

    assign eos      = !shift_en && shift_en_dly_q;
    assign mismatch = (hist_q[LATENCY-1] ^ resp_sr_q[OUT_LSB +: TEST_WIDTH]) & ~mask;
    // Bit 0 of each shift register only matters when the field starts at the chain LSB.
    assign unused_bits = ^{stim_sr_q[0], resp_sr_q[0]};

    always_comb begin
        stim_sr_d         = stim_sr_q;
        resp_sr_d         = resp_sr_q;
        bit_cnt_d         = bit_cnt_q;
        shift_en_dly_d    = shift_en;
        hist_d            = hist_q;
        hist_fill_d       = hist_fill_q;
        cmp_valid_d       = 1'b0;
        mismatch_bits_d   = mismatch_bits_q;
        error_d           = error_q;
        length_err_d      = length_err_q;
        err_count_d       = err_count_q;
        scan_count_d      = scan_count_q;
        first_fail_idx_d  = first_fail_idx_q;
        first_fail_bits_d = first_fail_bits_q;

        if (clear) begin
            bit_cnt_d         = '0;
            shift_en_dly_d    = 1'b0;
            hist_d            = '{default: '0};
            hist_fill_d       = '0;
            mismatch_bits_d   = '0;
            error_d           = 1'b0;
            length_err_d      = 1'b0;
            err_count_d       = '0;
            scan_count_d      = '0;
            first_fail_idx_d  = '0;
            first_fail_bits_d = '0;
        end else if (shift_en) begin
            stim_sr_d = {tdi, stim_sr_q[BSC_SIZE-1:1]};
            resp_sr_d = {tdo, resp_sr_q[BSC_SIZE-1:1]};
            if (bit_cnt_q != BC_SAT) bit_cnt_d = bit_cnt_q + BCW'(1);
        end else if (eos) begin
            bit_cnt_d = '0;
            if (bit_cnt_q == BC_FULL) begin
                if (hist_fill_q >= LAT && strobe) begin
                    cmp_valid_d     = 1'b1;
                    mismatch_bits_d = mismatch;
                    if (mismatch != '0) begin
                        error_d = 1'b1;
                        if (err_count_q != '1) err_count_d = err_count_q + CNT_W'(1);
                        // error is sticky, so it doubles as "first failure already captured".
                        if (!error_q) begin
                            first_fail_idx_d  = scan_count_q;
                            first_fail_bits_d = mismatch;
                        end
                    end
                end
                for (int i = LATENCY - 1; i > 0; i--) hist_d[i] = hist_q[i-1];
                hist_d[0] = stim_sr_q[OUT_LSB +: TEST_WIDTH];
                if (hist_fill_q < LAT) hist_fill_d = hist_fill_q + 3'(1);
                if (scan_count_q != '1) scan_count_d = scan_count_q + CNT_W'(1);
            end else begin
                length_err_d = 1'b1;
                hist_fill_d  = '0;
            end
        end
    end

    always_ff @(posedge TCK or negedge TRST_n) begin
        if (!TRST_n) begin
            stim_sr_q         <= '0;
            resp_sr_q         <= '0;
            bit_cnt_q         <= '0;
            shift_en_dly_q    <= 1'b0;
            hist_q            <= '{default: '0};
            hist_fill_q       <= '0;
            cmp_valid_q       <= 1'b0;
            mismatch_bits_q   <= '0;
            error_q           <= 1'b0;
            length_err_q      <= 1'b0;
            err_count_q       <= '0;
            scan_count_q      <= '0;
            first_fail_idx_q  <= '0;
            first_fail_bits_q <= '0;
        end else begin
            stim_sr_q         <= stim_sr_d;
            resp_sr_q         <= resp_sr_d;
            bit_cnt_q         <= bit_cnt_d;
            shift_en_dly_q    <= shift_en_dly_d;
            hist_q            <= hist_d;
            hist_fill_q       <= hist_fill_d;
            cmp_valid_q       <= cmp_valid_d;
            mismatch_bits_q   <= mismatch_bits_d;
            error_q           <= error_d;
            length_err_q      <= length_err_d;
            err_count_q       <= err_count_d;
            scan_count_q      <= scan_count_d;
            first_fail_idx_q  <= first_fail_idx_d;
            first_fail_bits_q <= first_fail_bits_d;
        end
    end

    assign cmp_valid       = cmp_valid_q;
    assign mismatch_bits   = mismatch_bits_q;
    assign error           = error_q;
    assign length_err      = length_err_q;
    assign err_count       = err_count_q;
    assign scan_count      = scan_count_q;
    assign first_fail_idx  = first_fail_idx_q;
    assign first_fail_bits = first_fail_bits_q;

endmodule

// File: tb/tb_jtag_scan_checker.sv
// Scoreboard bench for jtag_scan_checker: three instances (default, LATENCY=3, CNT_W=2)
// driven by directed scans; expected mismatch words are queued and popped on cmp_valid.
module tb_jtag_scan_checker;

    logic       TCK;
    logic       TRST_n;
    logic       sh_a  [3];
    logic       tdi_a [3];
    logic       tdo_a [3];
    logic       stb_a [3];
    logic       clr_a [3];
    logic [4:0] mask_a [3];

    logic        cv0, cv1, cv2;
    logic [4:0]  mm0, mm1, mm2, ffb0, ffb1, ffb2;
    logic        err0, err1, err2, lerr0, lerr1, lerr2;
    logic [15:0] ec0, sc0, ffi0, ec1, sc1, ffi1;
    logic [1:0]  ec2, sc2, ffi2;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [4:0] q0[$];
    logic [4:0] q1[$];
    logic [4:0] q2[$];

    jtag_scan_checker u0 (
        .TCK(TCK), .TRST_n(TRST_n), .tdi(tdi_a[0]), .tdo(tdo_a[0]), .shift_en(sh_a[0]),
        .strobe(stb_a[0]), .clear(clr_a[0]), .mask(mask_a[0]), .cmp_valid(cv0),
        .mismatch_bits(mm0), .error(err0), .length_err(lerr0), .err_count(ec0),
        .scan_count(sc0), .first_fail_idx(ffi0), .first_fail_bits(ffb0));

    jtag_scan_checker #(.LATENCY(3)) u1 (
        .TCK(TCK), .TRST_n(TRST_n), .tdi(tdi_a[1]), .tdo(tdo_a[1]), .shift_en(sh_a[1]),
        .strobe(stb_a[1]), .clear(clr_a[1]), .mask(mask_a[1]), .cmp_valid(cv1),
        .mismatch_bits(mm1), .error(err1), .length_err(lerr1), .err_count(ec1),
        .scan_count(sc1), .first_fail_idx(ffi1), .first_fail_bits(ffb1));

    jtag_scan_checker #(.CNT_W(2)) u2 (
        .TCK(TCK), .TRST_n(TRST_n), .tdi(tdi_a[2]), .tdo(tdo_a[2]), .shift_en(sh_a[2]),
        .strobe(stb_a[2]), .clear(clr_a[2]), .mask(mask_a[2]), .cmp_valid(cv2),
        .mismatch_bits(mm2), .error(err2), .length_err(lerr2), .err_count(ec2),
        .scan_count(sc2), .first_fail_idx(ffi2), .first_fail_bits(ffb2));

    initial begin
        TCK = 1'b0;
        forever #5 TCK = ~TCK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int d, input logic [4:0] e);
        case (d)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic pop_chk(input int d, input logic [4:0] act);
        logic [4:0] e;
        int sz;
        sz = (d == 0) ? q0.size() : (d == 1) ? q1.size() : q2.size();
        if (sz == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL u%0d_unexpected_cmp: got cmp_valid=1 mismatch_bits=%b, expected no compare", d, act);
        end else begin
            case (d)
                0:       e = q0.pop_front();
                1:       e = q1.pop_front();
                default: e = q2.pop_front();
            endcase
            chk($sformatf("u%0d_mismatch_bits", d), {27'b0, act}, {27'b0, e});
        end
    endtask

    always @(negedge TCK) begin
        if (cv0) pop_chk(0, mm0);
        if (cv1) pop_chk(1, mm1);
        if (cv2) pop_chk(2, mm2);
    end

    // One DR scan of n bits (LSB first), then the EOS edge carrying strobe/clear.
    task automatic scan(input int d, input int n, input logic [4:0] sf, input logic [4:0] rf,
                        input logic stb, input logic clr, input logic ec, input logic [4:0] em);
        logic [13:0] sv, rv;
        sv = {sf, 9'h15A};
        rv = {rf, 9'h0C3};
        for (int k = 0; k < n; k++) begin
            @(negedge TCK);
            sh_a[d]  = 1'b1;
            tdi_a[d] = sv[k];
            tdo_a[d] = rv[k];
        end
        @(negedge TCK);
        sh_a[d]  = 1'b0;
        tdi_a[d] = 1'b0;
        tdo_a[d] = 1'b0;
        stb_a[d] = stb;
        clr_a[d] = clr;
        if (ec) push_exp(d, em);
        @(negedge TCK);
        stb_a[d] = 1'b0;
        clr_a[d] = 1'b0;
    endtask

    initial begin
        TRST_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sh_a[i] = 0; tdi_a[i] = 0; tdo_a[i] = 0; stb_a[i] = 0; clr_a[i] = 0; mask_a[i] = '0;
        end
        repeat (3) @(negedge TCK);
        TRST_n = 1'b1;

        // Default instance: reset, pass, fail, mask, strobe=0, length error
        scan(0, 14, 5'b10110, 5'b00000, 1, 0, 0, 5'b0);
        chk("u0_scan_count_pre_reset", sc0, 1);
        for (int k = 0; k < 5; k++) begin
            @(negedge TCK);
            sh_a[0] = 1'b1; tdi_a[0] = k[0]; tdo_a[0] = 1'b1;
        end
        @(posedge TCK);
        #2;
        TRST_n  = 1'b0;
        sh_a[0] = 1'b0;
        #1;
        chk("u0_reset_scan_count", sc0, 0);
        chk("u0_reset_cmp_valid", cv0, 0);
        chk("u0_reset_error", err0, 0);
        chk("u0_reset_err_count", ec0, 0);
        @(negedge TCK);
        TRST_n = 1'b1;

        scan(0, 14, 5'b10110, 5'b00000, 1, 0, 0, 5'b0);
        chk("u0_scan_count_after_reset", sc0, 1);
        scan(0, 14, 5'b10110, 5'b10110, 1, 0, 1, 5'b00000);
        chk("u0_pass_error", err0, 0);
        chk("u0_pass_scan_count", sc0, 2);
        scan(0, 14, 5'b10110, 5'b10111, 1, 0, 1, 5'b00001);
        chk("u0_fail_error", err0, 1);
        chk("u0_fail_err_count", ec0, 1);
        chk("u0_first_fail_idx", ffi0, 2);
        chk("u0_first_fail_bits", ffb0, 5'b00001);
        scan(0, 14, 5'b10110, 5'b00110, 1, 0, 1, 5'b10000);
        chk("u0_fail2_err_count", ec0, 2);
        chk("u0_fail2_mismatch_bits", mm0, 5'b10000);
        chk("u0_fail2_first_fail_idx", ffi0, 2);
        chk("u0_fail2_first_fail_bits", ffb0, 5'b00001);
        mask_a[0] = 5'b00001;
        scan(0, 14, 5'b01010, 5'b10111, 1, 0, 1, 5'b00000);
        mask_a[0] = 5'b00000;
        chk("u0_masked_err_count", ec0, 2);
        scan(0, 14, 5'b01010, 5'b00000, 0, 0, 0, 5'b0);
        chk("u0_nostrobe_mismatch_hold", mm0, 5'b00000);
        chk("u0_nostrobe_scan_count", sc0, 6);
        chk("u0_length_err_before", lerr0, 0);
        scan(0, 13, 5'b11111, 5'b00000, 1, 0, 0, 5'b0);
        chk("u0_length_err", lerr0, 1);
        chk("u0_short_scan_count", sc0, 6);
        scan(0, 14, 5'b11001, 5'b00000, 1, 0, 0, 5'b0);
        chk("u0_realign_scan_count", sc0, 7);
        scan(0, 14, 5'b00000, 5'b11011, 1, 0, 1, 5'b00010);
        chk("u0_realign_err_count", ec0, 3);
        chk("u0_final_scan_count", sc0, 8);

        // LATENCY=3 instance
        scan(1, 14, 5'b10101, 5'b01010, 1, 0, 0, 5'b0);
        scan(1, 14, 5'b01100, 5'b01010, 1, 0, 0, 5'b0);
        scan(1, 14, 5'b11110, 5'b01010, 1, 0, 0, 5'b0);
        chk("u1_no_cmp_err_count", ec1, 0);
        scan(1, 14, 5'b00011, 5'b10100, 1, 0, 1, 5'b00001);
        scan(1, 14, 5'b00000, 5'b00000, 0, 0, 0, 5'b0);
        scan(1, 14, 5'b00000, 5'b11100, 1, 0, 1, 5'b00010);
        chk("u1_err_count", ec1, 2);
        chk("u1_scan_count", sc1, 6);
        chk("u1_first_fail_idx", ffi1, 3);

        // CNT_W=2 instance: saturation, clear on EOS, saturated first_fail_idx
        scan(2, 14, 5'b11111, 5'b11111, 1, 0, 0, 5'b0);
        for (int j = 0; j < 5; j++) scan(2, 14, 5'b11111, 5'b00000, 1, 0, 1, 5'b11111);
        chk("u2_err_count_sat", ec2, 3);
        chk("u2_scan_count_sat", sc2, 3);
        chk("u2_first_fail_idx", ffi2, 1);
        scan(2, 14, 5'b11111, 5'b00000, 1, 1, 0, 5'b0);
        chk("u2_clear_err_count", ec2, 0);
        chk("u2_clear_scan_count", sc2, 0);
        chk("u2_clear_error", err2, 0);
        chk("u2_clear_mismatch_bits", mm2, 0);
        chk("u2_clear_first_fail_bits", ffb2, 0);
        scan(2, 14, 5'b11111, 5'b00000, 1, 0, 0, 5'b0);
        chk("u2_post_clear_scan_count", sc2, 1);
        scan(2, 14, 5'b11111, 5'b11111, 1, 0, 1, 5'b00000);
        scan(2, 14, 5'b11111, 5'b11111, 1, 0, 1, 5'b00000);
        scan(2, 14, 5'b11111, 5'b11111, 1, 0, 1, 5'b00000);
        scan(2, 14, 5'b11111, 5'b01111, 1, 0, 1, 5'b10000);
        chk("u2_sat_first_fail_idx", ffi2, 3);
        chk("u2_sat_first_fail_bits", ffb2, 5'b10000);
        chk("u2_sat_err_count", ec2, 1);

        repeat (4) @(negedge TCK);
        chk("u0_expected_cmps_left", q0.size(), 0);
        chk("u1_expected_cmps_left", q1.size(), 0);
        chk("u2_expected_cmps_left", q2.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/jtag_scan_checker.md
# jtag_scan_checker

Parametrised TDO response checker for boundary-scan test benches, sitting beside the JTAG TAP of the device under test. It records the stimulus serially shifted into TDI and the response returned on TDO, and at the end of every complete DR scan compares a configurable response field against the expected values carried in the stimulus of an earlier scan. It adds the following over the single-field monitor:

- explicit shift-enable port;
- scan-length checking;
- configurable pipeline latency;
- compare mask;
- saturating error counter;
- first-failure capture.

## Interface
Parameters:
- BSC_SIZE, 14, scan chain length in bits (>= 2)
- TEST_WIDTH, 5, width of compared response field (1..BSC_SIZE)
- OUT_LSB, 9, LSB position of the field in the chain (OUT_LSB + TEST_WIDTH <= BSC_SIZE)
- LATENCY, 1, number of complete scans between stimulus and its response (1..4)
- CNT_W, 16, width of scan and error counters

Ports:
- TCK  in  1  test clock, all state on posedge
- TRST_n  in  1  reset, asynchronous, active-low
- tdi  in  1  stimulus bit being driven to the DUT TDI
- tdo  in  1  response bit from the DUT TDO
- shift_en  in  1  high for each TCK edge on which a bit is shifted
- strobe  in  1  compare enable, sampled at end-of-scan
- clear  in  1  synchronous clear of all status, counters and history
- mask  in  TEST_WIDTH  1 = ignore that field bit
- cmp_valid  out  1  one-cycle pulse: a comparison was made
- mismatch_bits  out  TEST_WIDTH  masked XOR of last comparison
- error  out  1  sticky, set by any non-zero comparison
- length_err  out  1  sticky, set by any scan with length != BSC_SIZE
- err_count  out  CNT_W  failing comparisons, saturating
- scan_count  out  CNT_W  valid scans seen, saturating
- first_fail_idx  out  CNT_W  scan_count value of the first failing scan
- first_fail_bits  out  TEST_WIDTH  mismatch_bits of the first failing scan

## Operation
- Shift: on each posedge with shift_en=1:
  - stim_sr <= {tdi, stim_sr[BSC_SIZE-1:1]};
  - resp_sr <= {tdo, resp_sr[BSC_SIZE-1:1]}, so the LSB-first bit ends at index 0;
  - bit_cnt increments, saturating at BSC_SIZE+1.
- End-of-scan (EOS): posedge where shift_en=0 and the registered shift_en_d=1.
- Valid EOS (bit_cnt == BSC_SIZE):
  - if hist_fill >= LATENCY and strobe=1: compare expected = hist[LATENCY-1][OUT_LSB +: TEST_WIDTH] against actual = resp_sr[OUT_LSB +: TEST_WIDTH];
  - mismatch = (expected ^ actual) & ~mask;
  - cmp_valid=1 and mismatch_bits=mismatch;
  - if mismatch != 0: error=1 and err_count++ (saturating); if this is the first failure since reset/clear, first_fail_idx=scan_count (pre-increment) and first_fail_bits=mismatch;
  - in all cases: push stim_sr into hist (hist[0] newest), hist_fill++ saturating at LATENCY, scan_count++ saturating.
- Invalid EOS (bit_cnt != BSC_SIZE):
  - length_err=1, no compare, no push;
  - hist_fill=0, because alignment is lost; the next LATENCY valid scans produce no compare.
- Every EOS clears bit_cnt to 0.
- strobe=0 at a valid EOS: history advances, no compare, mismatch_bits holds.
- clear=1: same state as reset except shift registers. It takes priority over the shift and EOS on that edge; that scan's data is discarded and bit_cnt=0.
- shift_en held 0: no state change except cmp_valid returning to 0.

## Timing
- Reset (TRST_n=0, immediate): all outputs 0; hist_fill=0; bit_cnt=0; shift_en_d=0.
- Reset mid-scan: partial scan is lost. The scan that follows reset is counted from bit 0.
- Compare latency: results update on the EOS edge, i.e. the first posedge after the last shifted bit. cmp_valid is high for exactly that one cycle.
- Back-to-back scans: shift_en may rise on the edge immediately after EOS. A one-cycle low gap is the minimum.
- err_count and scan_count stop at 2^CNT_W-1. A saturated scan_count still gives first_fail_idx the saturated value.
- mismatch_bits, first_fail_* hold between comparisons.

## Test plan
(BSC_SIZE=14, TEST_WIDTH=5, OUT_LSB=9, LATENCY=1 unless stated)
- Reset: drive TRST_n=0 mid-shift -> all outputs 0 asynchronously. Then one 14-bit scan -> scan_count=1, cmp_valid never pulses.
- Pass: scan0 stim bits[13:9]=5'b10110; scan1 returns resp bits[13:9]=5'b10110, strobe=1 -> cmp_valid pulse one edge after last bit, mismatch_bits=0, error=0, scan_count=2.
- Fail and first-fail: same but resp=5'b10111 -> mismatch_bits=5'b00001, error=1, err_count=1, first_fail_idx=1. A later failure with 5'b00110 changes err_count to 2 and mismatch_bits to 5'b10000, while first_fail_* are unchanged. The same failing case with mask=5'b00001 -> no error.
- Length: a 13-bit scan -> length_err=1, no cmp_valid, scan_count unchanged. The next valid 14-bit scan gives no compare; the one after compares against it.
- LATENCY=3: scans 0..2 give no compare. Scan 3 compares against scan 0 stimulus. With strobe=0 on scan 4 -> no pulse, but scan 5 compares against scan 2.
- CNT_W=2: five failing scans -> err_count=3 (saturated). Then clear=1 coincident with an EOS -> all counters/sticky 0, no cmp_valid, hist_fill=0.
